rr_ring_arbiter: RTL and testbench
==================================

// Module: rr_ring_arbiter
// PURPOSE
//  Round-robin arbiter granting one shared resource among N requesters.
//  - Priority is a one-hot ring pointer that rotates past each served requester.
//  - A hold timer force-releases any owner that keeps the resource too long.
//  - Sits between requesting blocks and a shared datapath; gnt/gnt_id drive the datapath select.
// PARAMETERS
//  N         4   number of requesters (N >= 2)
//  MAX_HOLD  8   max consecutive grant cycles per ownership (MAX_HOLD >= 1)
//  IDW       $clog2(N)   width of gnt_id (derived localparam, not overridable)
// PORTS
//  clk       in   1         single clock, all logic on posedge
//  rst       in   1         synchronous, active-high reset
//  req       in   N         request per requester; owner holds its bit high while using resource
//  gnt       out  N         one-hot grant, all-zero when no owner
//  gnt_id    out  IDW       binary index of owner, 0 when no owner
//  busy      out  1         1 while an owner holds the grant
//  expired   out  1         1-cycle pulse on the release cycle of a forced (timeout) release
//  prio      out  N         current one-hot priority pointer (debug/visibility)
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE, gnt=0, gnt_id=0, busy=0, expired=0, prio=0001 (bit0), hold_cnt=0.
//  All outputs are registered; rst wins over every other event, including mid-grant.
//  States: IDLE, GRANT.
//  IDLE:
//   - if req==0, stay in IDLE.
//   - else select the first set req bit at or after prio, scanning upward with wrap N-1 -> 0.
//   - next edge: gnt=onehot(sel), gnt_id=sel, busy=1, hold_cnt=0, go to GRANT.
//   - grant latency: 1 cycle from req sampled to gnt visible.
//  GRANT (owner = gnt_id):
//   - hold_cnt increments once per GRANT cycle.
//   - non-owner req bits are ignored.
//   - release when req[owner]==0 (voluntary) OR hold_cnt==MAX_HOLD-1 (forced).
//     Voluntary release wins when both hold.
//   - release edge: gnt=0, gnt_id=0, busy=0, go to IDLE.
//     prio = onehot(owner) rotated left by 1, with wrap 1000 -> 0001 for N=4.
//     expired=1 only if the release was forced; it clears on the next edge.
//   - max grant length is MAX_HOLD cycles.
//   - there is always >= 1 IDLE cycle (gnt=0) between two grants, as bus turnaround.
//  Invariants: gnt is one-hot or zero; busy == |gnt; prio is always exactly one-hot.
//  prio changes only on a release edge or reset.
//  A forced-off owner still requesting competes normally; it re-wins only if no other req is set.
// STRUCTURE
//  Package/header arb_pkg:
//   - state encodings ST_IDLE=1'b0, ST_GRANT=1'b1.
//   - default N/MAX_HOLD constants.
//  Sub-module ring_prio_ptr:
//   - N-bit one-hot rotate register with load-enable.
//   - reset value 1 (bit0).
//   - on enable, loads onehot(owner) rotated left by 1.
//  Top level holds:
//   - FSM.
//   - circular priority-select logic (double-width req masking, or a loop).
//   - hold counter of $clog2(MAX_HOLD+1) bits.
//   - output registers.
// TESTING  (N=4, MAX_HOLD=8; cycles counted from first posedge after stimulus applied)
//  1. Reset: rst=1 for 2 cycles with req=1111
//     -> gnt=0000, gnt_id=0, busy=0, expired=0, prio=0001 throughout.
//  2. Single voluntary: req=0100 at cycle t -> gnt=0100, gnt_id=2, busy=1 from t+1.
//     req->0000 at t+3 -> gnt=0000 at t+4, prio=1000, expired stays 0.
//  3. Fairness/wrap: req=1111, each owner drops its bit after 2 grant cycles then reasserts.
//     -> grant order 0001,0010,0100,1000,0001.
//     -> one gnt=0000 cycle between each grant; prio wraps 1000->0001.
//  4. Timeout: req=0011 held constant, prio=0001.
//     -> gnt=0001 for exactly 8 cycles, then gnt=0000 with expired=1 for 1 cycle.
//     -> next gnt=0010 (prio=0010).
//  5. Lone hog: only req=0001, held 30 cycles
//     -> repeating pattern of 8 grant cycles + 1 idle cycle; expired pulses each 9th cycle.
//  6. Reset mid-grant: rst=1 during cycle 3 of a grant to requester 2
//     -> next edge gnt=0000, busy=0, prio=0001, hold_cnt=0.
//     -> after rst=0 with req=0100, gnt=0100 one cycle later.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin ring arbiter.
package arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    localparam int ARB_N        = 4;
    localparam int ARB_MAX_HOLD = 8;

endpackage

// File: rtl/rr_ring_arbiter_if.sv
// Request/grant bundle between requesting blocks and the arbiter.
interface rr_ring_arbiter_if #(
    parameter int N = 4
);
    localparam int IDW = $clog2(N);

    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           busy;
    logic           expired;
    logic [N-1:0]   prio;

    modport master (
        output req,
        input  gnt, gnt_id, busy, expired, prio
    );

    modport slave (
        input  req,
        output gnt, gnt_id, busy, expired, prio
    );

endinterface

// File: rtl/ring_prio_ptr.sv
// One-hot priority ring; loads the slot just past the released owner.
module ring_prio_ptr #(
    parameter int N = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en_i,
    input  logic [IDW-1:0] owner_i,
    output logic [N-1:0]   prio_o
);

    logic [N-1:0] prio_q;
    logic [N-1:0] owner_oh;

    assign owner_oh = N'(1) << owner_i;
    assign prio_o   = prio_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= N'(1);
        end else if (en_i) begin
            prio_q <= {owner_oh[N-2:0], owner_oh[N-1]};
        end
    end

endmodule

// File: rtl/rr_ring_arbiter.sv
// Round-robin arbiter with rotating one-hot priority and a hold timeout.
module rr_ring_arbiter
    import arb_pkg::*;
#(
    parameter int N        = ARB_N,
    parameter int MAX_HOLD = ARB_MAX_HOLD
) (
    input logic              clk,
    input logic              rst,
    rr_ring_arbiter_if.slave bus
);

    localparam int IDW = $clog2(N);
    localparam int HW  = $clog2(MAX_HOLD + 1);

    arb_state_e     state_q;
    logic [N-1:0]   gnt_q;
    logic [IDW-1:0] id_q;
    logic           busy_q;
    logic           exp_q;
    logic [HW-1:0]  hold_q;
    logic [N-1:0]   prio;

    logic [2*N-1:0] req_dbl;
    logic [IDW-1:0] sel;
    logic           found;
    int             p_idx;
    logic           owner_req;
    logic           hold_max;
    logic           rel;

    assign req_dbl = {bus.req, bus.req};

    // Scan the doubled request vector from the pointer so the wrap is free.
    always_comb begin
        p_idx = 0;
        for (int i = 0; i < N; i++) begin
            if (prio[i]) p_idx = i;
        end
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < 2 * N; i++) begin
            if (!found && i >= p_idx && req_dbl[i]) begin
                sel   = IDW'(i % N);
                found = 1'b1;
            end
        end
    end

    assign owner_req = bus.req[id_q];
    assign hold_max  = (hold_q == HW'(MAX_HOLD - 1));
    assign rel       = (state_q == ST_GRANT) && (!owner_req || hold_max);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            busy_q  <= 1'b0;
            exp_q   <= 1'b0;
            hold_q  <= '0;
        end else begin
            exp_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (found) begin
                        state_q <= ST_GRANT;
                        gnt_q   <= N'(1) << sel;
                        id_q    <= sel;
                        busy_q  <= 1'b1;
                        hold_q  <= '0;
                    end
                end
                ST_GRANT: begin
                    if (rel) begin
                        state_q <= ST_IDLE;
                        gnt_q   <= '0;
                        id_q    <= '0;
                        busy_q  <= 1'b0;
                        // Still requesting at release means the timer forced it.
                        exp_q   <= owner_req;
                        hold_q  <= '0;
                    end else begin
                        hold_q <= hold_q + HW'(1);
                    end
                end
            endcase
        end
    end

    ring_prio_ptr #(
        .N(N)
    ) u_prio (
        .clk    (clk),
        .rst    (rst),
        .en_i   (rel),
        .owner_i(id_q),
        .prio_o (prio)
    );

    assign bus.gnt     = gnt_q;
    assign bus.gnt_id  = id_q;
    assign bus.busy    = busy_q;
    assign bus.expired = exp_q;
    assign bus.prio    = prio;

endmodule

// File: tb/tb_rr_ring_arbiter.sv
// Scoreboard bench for rr_ring_arbiter (N=4, MAX_HOLD=8).
module tb_rr_ring_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 8;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] id;
        logic       busy;
        logic       exp;
        logic [3:0] prio;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   done = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t       sb_q[$];
    logic [3:0] order_q[$];
    logic [3:0] prev_gnt = '0;

    int m_st   = 0;
    int m_own  = 0;
    int m_len  = 0;
    int m_pidx = 0;
    bit m_exp  = 1'b0;

    rr_ring_arbiter_if #(.N(N)) bus();

    rr_ring_arbiter #(
        .N       (N),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Reference model: grant length counted 1..MAX_HOLD, pointer as an index.
    always @(posedge clk) begin
        exp_t e;
        bit   hit;
        if (rst) begin
            m_st = 0; m_own = 0; m_len = 0; m_pidx = 0; m_exp = 1'b0;
        end else begin
            m_exp = 1'b0;
            if (m_st == 0) begin
                if (bus.req != 4'b0) begin
                    hit = 1'b0;
                    for (int k = 0; k < N; k++) begin
                        if (!hit && bus.req[(m_pidx + k) % N]) begin
                            m_own = (m_pidx + k) % N;
                            hit   = 1'b1;
                        end
                    end
                    m_st  = 1;
                    m_len = 1;
                end
            end else if (!bus.req[m_own] || m_len == MAX_HOLD) begin
                m_exp  = bus.req[m_own];
                m_pidx = (m_own + 1) % N;
                m_st   = 0;
            end else begin
                m_len++;
            end
        end
        e.gnt  = (m_st == 1) ? 4'(1 << m_own) : 4'b0;
        e.id   = (m_st == 1) ? 2'(m_own) : 2'd0;
        e.busy = (m_st == 1);
        e.exp  = m_exp;
        e.prio = 4'(1 << m_pidx);
        sb_q.push_back(e);
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!done) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_empty", 32'd0, 32'd1);
            end else begin
                e = sb_q.pop_front();
                check_eq("gnt",     32'(bus.gnt),     32'(e.gnt));
                check_eq("gnt_id",  32'(bus.gnt_id),  32'(e.id));
                check_eq("busy",    32'(bus.busy),    32'(e.busy));
                check_eq("expired", 32'(bus.expired), 32'(e.exp));
                check_eq("prio",    32'(bus.prio),    32'(e.prio));
            end
            if (bus.gnt != 4'b0 && prev_gnt == 4'b0) order_q.push_back(bus.gnt);
            prev_gnt = bus.gnt;
        end
    end

    task automatic do_reset(input logic [3:0] r, input int cycles);
        @(negedge clk);
        rst     = 1'b1;
        bus.req = r;
        repeat (cycles) @(negedge clk);
        rst     = 1'b0;
        bus.req = 4'b0;
    endtask

    initial begin
        int held;
        int cnt;
        int ecnt;
        logic [3:0] want;
        bus.req = 4'hF;

        // Reset held with all requests asserted
        do_reset(4'hF, 2);
        repeat (2) @(negedge clk);

        // Single voluntary grant to requester 2
        bus.req = 4'b0100;
        repeat (3) @(negedge clk);
        bus.req = 4'b0000;
        repeat (3) @(negedge clk);

        // Fairness and wrap with every requester active
        do_reset(4'b0, 1);
        order_q.delete();
        held    = 0;
        bus.req = 4'hF;
        repeat (16) begin
            @(negedge clk);
            if (bus.gnt != 4'b0) held++;
            else held = 0;
            bus.req = (held >= 2) ? (4'hF & ~bus.gnt) : 4'hF;
        end
        check_eq("order_len", 32'(order_q.size() >= 5), 32'd1);
        want = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            if (i < order_q.size())
                check_eq($sformatf("order%0d", i), 32'(order_q[i]), 32'(want));
            want = {want[2:0], want[3]};
        end

        // Timeout with two competing requesters
        do_reset(4'b0, 1);
        bus.req = 4'b0011;
        cnt  = 0;
        ecnt = 0;
        repeat (14) begin
            @(negedge clk);
            if (bus.gnt == 4'b0001) cnt++;
            if (bus.expired) ecnt++;
        end
        check_eq("timeout_len", 32'(cnt), 32'd8);
        check_eq("timeout_exp", 32'(ecnt), 32'd1);
        check_eq("after_timeout", 32'(bus.gnt), 32'b0010);

        // Lone hog repeatedly timed out
        do_reset(4'b0, 1);
        bus.req = 4'b0001;
        ecnt = 0;
        cnt  = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.expired) ecnt++;
            if (bus.gnt == 4'b0) cnt++;
        end
        check_eq("hog_exp", 32'(ecnt), 32'd3);
        check_eq("hog_idle", 32'(cnt), 32'd3);

        // Reset in the middle of a grant
        do_reset(4'b0, 1);
        bus.req = 4'b0100;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_gnt", 32'(bus.gnt), 32'd0);
        check_eq("midrst_prio", 32'(bus.prio), 32'b0001);
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_gnt", 32'(bus.gnt), 32'b0100);
        bus.req = 4'b0;
        repeat (3) @(negedge clk);

        done = 1'b1;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
